// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES key expansion, one 32-bit word per clock.
// SubWord is computed by an external combinational 4-lane S-box. The schedule
// is held in a register array and read out one 128-bit round key at a time.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE; busy
// is high for every EXPAND cycle; done pulses for exactly one cycle (DONE)
// after the last word is written, together with rk_valid rising. rk_valid then
// holds until the next accepted start or reset. Starts seen outside IDLE are
// dropped; there is no queueing.
module key_schedule_ctrl #(
  parameter int NK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [0:32*NK-1]    key_in,
  output logic                busy,
  output logic                done,
  output logic                rk_valid,
  output logic [0:31]         sbox_word_out,
  input  logic [0:31]         sbox_word_in,
  input  logic [0:3]          rk_rd_round,
  output logic [0:127]        rk_rd_data,
  output logic [1:0]          o_dbg_state
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);

  localparam logic [5:0] NK_I   = 6'(NK);
  localparam logic [5:0] LAST_I = 6'(TOTAL - 1);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);
  localparam logic [3:0] NR_R   = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [0:31]  r_w [0:TOTAL-1];
  logic [5:0]   r_i;
  logic [2:0]   r_mod;
  logic [7:0]   r_rcon;
  logic         r_valid;

  logic         w_load;
  logic         w_expand;
  logic         w_use_rot;
  logic         w_use_sub;
  logic [0:31]  w_prev;
  logic [0:31]  w_back;
  logic [0:31]  w_t;
  logic [0:31]  w_new;
  logic [7:0]   w_rcon_next;
  logic         w_rd_ok;
  logic [5:0]   w_rd_base;

  assign w_load   = (r_state == S_IDLE) && start;
  assign w_expand = (r_state == S_EXPAND);

  // State register; reset aborts any expansion in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_next = S_EXPAND;
      S_EXPAND: if (r_i == LAST_I) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Word recurrence: choose t from i mod NK and drive the external S-box.
  always_comb begin
    w_prev        = r_w[r_i - 6'd1];
    w_back        = r_w[r_i - NK_I];
    w_use_rot     = (r_mod == 3'd0);
    w_use_sub     = (NK == 8) && (r_mod == 3'd4);
    sbox_word_out = '0;
    w_t           = w_prev;
    if (w_expand && w_use_rot) begin
      sbox_word_out = {w_prev[8:31], w_prev[0:7]};
      w_t           = sbox_word_in ^ {r_rcon, 24'h0};
    end else if (w_expand && w_use_sub) begin
      sbox_word_out = w_prev;
      w_t           = sbox_word_in;
    end
    w_new       = w_back ^ w_t;
    w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  // Word index, i mod NK wrap counter, Rcon and the valid flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_i     <= '0;
      r_mod   <= '0;
      r_rcon  <= 8'h01;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_i     <= NK_I;
      r_mod   <= '0;
      r_rcon  <= 8'h01;
      r_valid <= 1'b0;
    end else if (w_expand) begin
      r_i   <= r_i + 6'd1;
      r_mod <= (r_mod == NK_M1) ? 3'd0 : r_mod + 3'd1;
      if (w_use_rot) r_rcon <= w_rcon_next;
      if (r_i == LAST_I) r_valid <= 1'b1;
    end
  end

  // Word array: key words on load, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < NK; k++) r_w[k] <= key_in[32*k +: 32];
    end else if (w_expand) begin
      r_w[r_i] <= w_new;
    end
  end

  // Round-key read port; index clamped so out-of-range rounds never index past the array.
  always_comb begin
    w_rd_ok    = r_valid && (rk_rd_round <= NR_R);
    w_rd_base  = {(w_rd_ok ? rk_rd_round : 4'd0), 2'b00};
    rk_rd_data = '0;
    if (w_rd_ok)
      rk_rd_data = {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                    r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
  end

  assign busy        = w_expand;
  assign done        = (r_state == S_DONE);
  assign rk_valid    = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with NK = 4, 6 and 8 instances, each
// served by a combinational AES S-box model. Expected round keys are the
// published AES key-expansion vectors.
module tb_key_schedule_ctrl;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [0:127] KEY4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:191] KEY6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [0:255] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] BAD4 = 128'hdeadbeef0123456789abcdeffedcba98;

  localparam logic [0:127] K4_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] K4_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [0:127] K4_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] K6_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [0:127] K6_R1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [0:127] K6_R12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [0:127] K8_R0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [0:127] K8_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] K8_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [0:127] K8_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  function automatic logic [0:31] sub_word(input logic [0:31] a);
    return {SBOX[a[0:7]], SBOX[a[8:15]], SBOX[a[16:23]], SBOX[a[24:31]]};
  endfunction

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
  logic [0:127] key4 = '0;
  logic [0:191] key6 = '0;
  logic [0:255] key8 = '0;
  logic [0:3]   rd4 = '0, rd6 = '0, rd8 = '0;
  logic         busy4, busy6, busy8, done4, done6, done8, valid4, valid6, valid8;
  logic [0:31]  sbo4, sbo6, sbo8, sbi4, sbi6, sbi8;
  logic [0:127] rdata4, rdata6, rdata8;
  logic [1:0]   st4, st6, st8;

  assign sbi4 = sub_word(sbo4);
  assign sbi6 = sub_word(sbo6);
  assign sbi8 = sub_word(sbo8);

  key_schedule_ctrl #(.NK(4)) u_nk4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .rk_valid(valid4),
    .sbox_word_out(sbo4), .sbox_word_in(sbi4),
    .rk_rd_round(rd4), .rk_rd_data(rdata4), .o_dbg_state(st4));

  key_schedule_ctrl #(.NK(6)) u_nk6 (
    .clk(clk), .reset_n(reset_n), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .rk_valid(valid6),
    .sbox_word_out(sbo6), .sbox_word_in(sbi6),
    .rk_rd_round(rd6), .rk_rd_data(rdata6), .o_dbg_state(st6));

  key_schedule_ctrl #(.NK(8)) u_nk8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .rk_valid(valid8),
    .sbox_word_out(sbo8), .sbox_word_in(sbi8),
    .rk_rd_round(rd8), .rk_rd_data(rdata8), .o_dbg_state(st8));

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start4(input logic [0:127] k);
    key4 = k; start4 = 1'b1; tick(); start4 = 1'b0;
  endtask

  task automatic pulse_start6(input logic [0:191] k);
    key6 = k; start6 = 1'b1; tick(); start6 = 1'b0;
  endtask

  task automatic pulse_start8(input logic [0:255] k);
    key8 = k; start8 = 1'b1; tick(); start8 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_vec++; if ({busy4, done4, valid4} !== 3'b000) begin n_err++; $display("FAIL reset_flags4 got %b want 000", {busy4, done4, valid4}); end
    n_vec++; if ({busy6, done6, valid6} !== 3'b000) begin n_err++; $display("FAIL reset_flags6 got %b want 000", {busy6, done6, valid6}); end
    n_vec++; if ({busy8, done8, valid8} !== 3'b000) begin n_err++; $display("FAIL reset_flags8 got %b want 000", {busy8, done8, valid8}); end
    n_vec++; if (st4 !== 2'd0) begin n_err++; $display("FAIL reset_state4 got %0d want 0", st4); end
    rd4 = 4'd0; #1;
    n_vec++; if (rdata4 !== 128'h0) begin n_err++; $display("FAIL reset_read4 got %h want 0", rdata4); end
    n_vec++; if (sbo4 !== 32'h0) begin n_err++; $display("FAIL reset_sbox_out4 got %h want 0", sbo4); end
  endtask

  task automatic test_nk4();
    int n;
    pulse_start4(KEY4);
    n_vec++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL nk4_valid_during got %b want 0", valid4); end
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (n !== 40) begin n_err++; $display("FAIL nk4_busy_cycles got %0d want 40", n); end
    n_vec++; if (done4 !== 1'b1) begin n_err++; $display("FAIL nk4_done_at_41 got %b want 1", done4); end
    n_vec++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL nk4_valid got %b want 1", valid4); end
    tick();
    n_vec++; if (done4 !== 1'b0) begin n_err++; $display("FAIL nk4_done_width got %b want 0", done4); end
    n_vec++; if (st4 !== 2'd0) begin n_err++; $display("FAIL nk4_back_idle got %0d want 0", st4); end
    rd4 = 4'd0; #1;
    n_vec++; if (rdata4 !== KEY4) begin n_err++; $display("FAIL nk4_round0 got %h want %h", rdata4, KEY4); end
    rd4 = 4'd1; #1;
    n_vec++; if (rdata4 !== K4_R1) begin n_err++; $display("FAIL nk4_round1 got %h want %h", rdata4, K4_R1); end
    rd4 = 4'd2; #1;
    n_vec++; if (rdata4 !== K4_R2) begin n_err++; $display("FAIL nk4_round2 got %h want %h", rdata4, K4_R2); end
    rd4 = 4'd10; #1;
    n_vec++; if (rdata4 !== K4_R10) begin n_err++; $display("FAIL nk4_round10 got %h want %h", rdata4, K4_R10); end
    rd4 = 4'd11; #1;
    n_vec++; if (rdata4 !== 128'h0) begin n_err++; $display("FAIL nk4_round11 got %h want 0", rdata4); end
    rd4 = 4'd15; #1;
    n_vec++; if (rdata4 !== 128'h0) begin n_err++; $display("FAIL nk4_round15 got %h want 0", rdata4); end
  endtask

  task automatic test_nk6();
    int n;
    pulse_start6(KEY6);
    n = 0;
    while (busy6 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (n !== 46) begin n_err++; $display("FAIL nk6_busy_cycles got %0d want 46", n); end
    n_vec++; if ({done6, valid6} !== 2'b11) begin n_err++; $display("FAIL nk6_done_valid got %b want 11", {done6, valid6}); end
    tick();
    rd6 = 4'd0; #1;
    n_vec++; if (rdata6 !== K6_R0) begin n_err++; $display("FAIL nk6_round0 got %h want %h", rdata6, K6_R0); end
    rd6 = 4'd1; #1;
    n_vec++; if (rdata6 !== K6_R1) begin n_err++; $display("FAIL nk6_round1 got %h want %h", rdata6, K6_R1); end
    rd6 = 4'd12; #1;
    n_vec++; if (rdata6 !== K6_R12) begin n_err++; $display("FAIL nk6_round12 got %h want %h", rdata6, K6_R12); end
    rd6 = 4'd13; #1;
    n_vec++; if (rdata6 !== 128'h0) begin n_err++; $display("FAIL nk6_round13 got %h want 0", rdata6); end
  endtask

  task automatic test_nk8();
    int n;
    pulse_start8(KEY8);
    n = 0;
    while (busy8 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (n !== 52) begin n_err++; $display("FAIL nk8_busy_cycles got %0d want 52", n); end
    n_vec++; if ({done8, valid8} !== 2'b11) begin n_err++; $display("FAIL nk8_done_valid got %b want 11", {done8, valid8}); end
    tick();
    rd8 = 4'd0; #1;
    n_vec++; if (rdata8 !== K8_R0) begin n_err++; $display("FAIL nk8_round0 got %h want %h", rdata8, K8_R0); end
    rd8 = 4'd1; #1;
    n_vec++; if (rdata8 !== K8_R1) begin n_err++; $display("FAIL nk8_round1 got %h want %h", rdata8, K8_R1); end
    rd8 = 4'd2; #1;
    n_vec++; if (rdata8 !== K8_R2) begin n_err++; $display("FAIL nk8_round2 got %h want %h", rdata8, K8_R2); end
    rd8 = 4'd14; #1;
    n_vec++; if (rdata8 !== K8_R14) begin n_err++; $display("FAIL nk8_round14 got %h want %h", rdata8, K8_R14); end
    rd8 = 4'd15; #1;
    n_vec++; if (rdata8 !== 128'h0) begin n_err++; $display("FAIL nk8_round15 got %h want 0", rdata8); end
  endtask

  task automatic test_restart_ignored();
    int n;
    pulse_start4(KEY4);
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin
      if (n == 10) begin key4 = BAD4; start4 = 1'b1; end
      else start4 = 1'b0;
      n++; tick();
    end
    start4 = 1'b0;
    n_vec++; if (n !== 40) begin n_err++; $display("FAIL restart_busy_cycles got %0d want 40", n); end
    n_vec++; if (done4 !== 1'b1) begin n_err++; $display("FAIL restart_done got %b want 1", done4); end
    start4 = 1'b1; tick(); start4 = 1'b0;
    n_vec++; if ({st4, busy4, valid4} !== 4'b0001) begin n_err++; $display("FAIL restart_in_done state/busy/valid got %b want 0001", {st4, busy4, valid4}); end
    tick();
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL restart_no_relaunch got %b want 0", busy4); end
    rd4 = 4'd1; #1;
    n_vec++; if (rdata4 !== K4_R1) begin n_err++; $display("FAIL restart_round1 got %h want %h", rdata4, K4_R1); end
    rd4 = 4'd10; #1;
    n_vec++; if (rdata4 !== K4_R10) begin n_err++; $display("FAIL restart_round10 got %h want %h", rdata4, K4_R10); end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    pulse_start4(KEY4);
    repeat (19) tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    n_vec++; if ({busy4, done4, valid4} !== 3'b000) begin n_err++; $display("FAIL abort_flags got %b want 000", {busy4, done4, valid4}); end
    n_vec++; if (st4 !== 2'd0) begin n_err++; $display("FAIL abort_state got %0d want 0", st4); end
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
      tick();
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    rd4 = 4'd0; #1;
    n_vec++; if (rdata4 !== 128'h0) begin n_err++; $display("FAIL abort_read_invalid got %h want 0", rdata4); end
    pulse_start4(KEY4);
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (n !== 40) begin n_err++; $display("FAIL abort_rerun_cycles got %0d want 40", n); end
    tick();
    rd4 = 4'd1; #1;
    n_vec++; if (rdata4 !== K4_R1) begin n_err++; $display("FAIL abort_round1 got %h want %h", rdata4, K4_R1); end
    rd4 = 4'd10; #1;
    n_vec++; if (rdata4 !== K4_R10) begin n_err++; $display("FAIL abort_round10 got %h want %h", rdata4, K4_R10); end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_start4(KEY4);
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (done4 !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", done4); end
    tick();
    pulse_start4(KEY4);
    n_vec++; if ({busy4, valid4} !== 2'b10) begin n_err++; $display("FAIL b2b_accept busy/valid got %b want 10", {busy4, valid4}); end
    rd4 = 4'd3; #1;
    n_vec++; if (rdata4 !== 128'h0) begin n_err++; $display("FAIL b2b_read_invalid got %h want 0", rdata4); end
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin n++; tick(); end
    n_vec++; if (n !== 40) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 40", n); end
    n_vec++; if ({done4, valid4} !== 2'b11) begin n_err++; $display("FAIL b2b_done_valid got %b want 11", {done4, valid4}); end
    rd4 = 4'd10; #1;
    n_vec++; if (rdata4 !== K4_R10) begin n_err++; $display("FAIL b2b_round10 got %h want %h", rdata4, K4_R10); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nk4();
    test_nk6();
    test_nk8();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
